// File: rtl/vadd_pkg.sv
// Shared definitions for the binary16 vector adder: field positions,
// special encodings, the element type and the controller state encoding.
package vadd_pkg;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_MSB  = 9;
    localparam int BIAS     = 15;
    localparam logic [4:0] EXP_MAX = 5'h1F;

    typedef logic [15:0] fp16_t;

    localparam fp16_t QNAN = 16'h7E00;
    localparam fp16_t PINF = 16'h7C00;
    localparam fp16_t MAXF = 16'h7BFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/vec_fp16_add_seq_fp16_add_unit.sv
// Combinational single-lane binary16 adder with round-to-nearest-even.
// Subnormal inputs act as signed zero, underflow flushes to +0.
// Build option VADD_SAT_EN: overflow saturates to +/-max finite instead of +/-inf.
module fp16_add_unit
    import vadd_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t sum,
    output logic  ovf
);

    // Round an aligned 14-bit significand (11 kept bits, guard, round, sticky)
    // to 11 bits; bit 11 of the result flags a carry out of the mantissa.
    function automatic logic [11:0] round_rne(input logic [13:0] n);
        logic inc;
        inc = n[2] & (n[1] | n[0] | n[3]);
        return {1'b0, n[13:3]} + {11'b0, inc};
    endfunction

    // Encoding returned when a finite sum exceeds the largest finite value.
    function automatic fp16_t ovf_result(input logic s);
`ifdef VADD_SAT_EN
        return {s, MAXF[14:0]};
`else
        return {s, PINF[14:0]};
`endif
    endfunction

    logic [4:0]  ea, eb, e_big, e_small, diff;
    logic [9:0]  ma, mb;
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        swap, s_big, eff_sub, sticky, found;
    logic [10:0] m_big, m_small;
    logic [13:0] big_x, small_x, small_al, lost_mask, norm;
    logic [14:0] raw;
    logic [3:0]  lz;
    logic [11:0] rnd;
    logic signed [6:0] e_norm, e_fin;
    logic [9:0]  frac;

    assign sa = a[SIGN_BIT];
    assign sb = b[SIGN_BIT];
    assign ea = a[EXP_MSB:EXP_LSB];
    assign eb = b[EXP_MSB:EXP_LSB];
    assign ma = a[MAN_MSB:0];
    assign mb = b[MAN_MSB:0];

    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    // Finite path: align smaller magnitude, add/subtract, normalise, round.
    always_comb begin
        swap     = (b[14:0] > a[14:0]);
        s_big    = swap ? sb : sa;
        e_big    = swap ? eb : ea;
        e_small  = swap ? ea : eb;
        m_big    = {1'b1, (swap ? mb : ma)};
        m_small  = {1'b1, (swap ? ma : mb)};
        eff_sub  = sa ^ sb;
        diff     = e_big - e_small;
        big_x    = {m_big, 3'b000};
        small_x  = {m_small, 3'b000};
        lost_mask = '0;
        small_al = '0;
        sticky   = 1'b0;
        if (diff >= 5'd14) begin
            sticky = 1'b1;
        end else begin
            lost_mask = ~(14'h3FFF << diff);
            small_al  = small_x >> diff;
            sticky    = |(small_x & lost_mask);
        end
        small_al[0] = small_al[0] | sticky;

        raw = eff_sub ? ({1'b0, big_x} - {1'b0, small_al})
                      : ({1'b0, big_x} + {1'b0, small_al});

        lz    = '0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found) begin
                if (raw[i]) found = 1'b1;
                else        lz = lz + 4'd1;
            end
        end

        if (raw[14]) begin
            norm   = {raw[14:2], raw[1] | raw[0]};
            e_norm = $signed({2'b00, e_big}) + 7'sd1;
        end else begin
            norm   = raw[13:0] << lz;
            e_norm = $signed({2'b00, e_big}) - $signed({3'b000, lz});
        end

        rnd = round_rne(norm);
        if (rnd[11]) begin
            e_fin = e_norm + 7'sd1;
            frac  = rnd[10:1];
        end else begin
            e_fin = e_norm;
            frac  = rnd[9:0];
        end
    end

    // Special-case selection ahead of the finite result.
    always_comb begin
        sum = '0;
        ovf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum = QNAN;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (a_zero && b_zero) begin
            sum = {sa & sb, 15'b0};
        end else if (a_zero) begin
            sum = b;
        end else if (b_zero) begin
            sum = a;
        end else if (raw == '0 || e_fin < 7'sd1) begin
            sum = '0;
        end else if (e_fin >= 7'sd31) begin
            sum = ovf_result(s_big);
            ovf = 1'b1;
        end else begin
            sum = {s_big, e_fin[4:0], frac};
        end
    end

endmodule

// File: rtl/vec_fp16_add_seq.sv
// Sequential binary16 vector adder: LANES elements, PAR lanes per beat,
// start/busy/done handshake. Build option VADD_SAT_EN (in fp16_add_unit)
// selects saturating overflow.
module vec_fp16_add_seq
    import vadd_pkg::*;
#(
    parameter int LANES = 16,
    parameter int PAR   = 4,
    parameter int EW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LANES*EW-1:0]   a,
    input  logic [LANES*EW-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [LANES*EW-1:0]   sum,
    output logic [LANES-1:0]      ovf_lane,
    output logic                  g_flag
);

    localparam int BEATS = LANES / PAR;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    if (EW != 16 || (LANES % PAR) != 0) begin : g_bad_cfg
        $error("vec_fp16_add_seq: EW must be 16 and LANES a multiple of PAR");
    end

    state_t              state, state_next;
    logic [BW-1:0]       beat;
    logic [LANES*EW-1:0] op_a, op_b;
    logic [PAR*EW-1:0]   cur_a, cur_b, res;
    logic [PAR-1:0]      res_ovf;
    logic                accept;

    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (beat == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on an accepted start; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= b;
        end
    end

    // Select the operand slice for the current beat.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat == BW'(k)) begin
                cur_a = op_a[k*PAR*EW +: PAR*EW];
                cur_b = op_b[k*PAR*EW +: PAR*EW];
            end
        end
    end

    for (genvar g = 0; g < PAR; g++) begin : g_lane
        fp16_add_unit u_add (
            .a   (cur_a[g*EW +: EW]),
            .b   (cur_b[g*EW +: EW]),
            .sum (res[g*EW +: EW]),
            .ovf (res_ovf[g])
        );
    end

    // Beat counter, result write-back, done pulse and global flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            done     <= 1'b0;
            g_flag   <= 1'b0;
            ovf_lane <= '0;
            sum      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                beat     <= '0;
                ovf_lane <= '0;
                g_flag   <= 1'b0;
            end
            if (state == RUN) begin
                beat <= beat + BW'(1);
                for (int k = 0; k < BEATS; k++) begin
                    if (beat == BW'(k)) begin
                        sum[k*PAR*EW +: PAR*EW] <= res;
                        ovf_lane[k*PAR +: PAR]  <= res_ovf;
                    end
                end
            end
            if (state == DONE) begin
                done   <= 1'b1;
                g_flag <= |ovf_lane;
            end
        end
    end

endmodule
